// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes the raw pins, frames 11-bit words and
// resolves E0/F0 prefixes into registered make/break/error pulses.
module ps2_scancode_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       ext,
   output logic       recv,
   output logic       rel,
   output logic       err
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

   logic             pc_s1_q, pc_s2_q, pc_s3_q;
   logic             pd_s1_q, pd_s2_q;
   state_e           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic             brk_f_q, brk_f_d;
   logic             ext_f_q, ext_f_d;
   logic [7:0]       code_q, code_d;
   logic             ext_q, ext_d;
   logic             recv_q, recv_d;
   logic             rel_q, rel_d;
   logic             err_q, err_d;
   logic             sample_c;
   logic             good_c;

   assign sample_c = pc_s3_q & ~pc_s2_q;
   assign good_c   = (^{shift_q, parity_q}) & pd_s2_q;

   // Next-state: frame FSM, watchdog and byte layer
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      wd_d      = wd_q;
      brk_f_d   = brk_f_q;
      ext_f_d   = ext_f_q;
      code_d    = code_q;
      ext_d     = ext_q;
      recv_d    = 1'b0;
      rel_d     = 1'b0;
      err_d     = 1'b0;

      if ((state_q == S_IDLE) || sample_c) begin
         wd_d = '0;
      end else if (wd_q != CNT_MAX) begin
         wd_d = wd_q + CNT_W'(1);
      end

      if (sample_c) begin
         unique case (state_q)
            S_IDLE: begin
               if (!pd_s2_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
               end
            end
            S_DATA: begin
               shift_d   = {pd_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               parity_d = pd_s2_q;
               state_d  = S_STOP;
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (!good_c) begin
                  err_d   = 1'b1;
                  brk_f_d = 1'b0;
                  ext_f_d = 1'b0;
               end else if (shift_q == 8'hF0) begin
                  brk_f_d = 1'b1;
               end else if (shift_q == 8'hE0) begin
                  ext_f_d = 1'b1;
               end else begin
                  code_d  = shift_q;
                  ext_d   = ext_f_q;
                  rel_d   = brk_f_q;
                  recv_d  = ~brk_f_q;
                  brk_f_d = 1'b0;
                  ext_f_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else if ((state_q != S_IDLE) && (wd_q == CNT_MAX)) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         brk_f_d = 1'b0;
         ext_f_d = 1'b0;
      end
   end

   // Synchronizer flops idle high so reset release never looks like an edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_s1_q   <= 1'b1;
         pc_s2_q   <= 1'b1;
         pc_s3_q   <= 1'b1;
         pd_s1_q   <= 1'b1;
         pd_s2_q   <= 1'b1;
         state_q   <= S_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'h00;
         parity_q  <= 1'b0;
         wd_q      <= '0;
         brk_f_q   <= 1'b0;
         ext_f_q   <= 1'b0;
         code_q    <= 8'h00;
         ext_q     <= 1'b0;
         recv_q    <= 1'b0;
         rel_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         pc_s1_q   <= ps2_clk;
         pc_s2_q   <= pc_s1_q;
         pc_s3_q   <= pc_s2_q;
         pd_s1_q   <= ps2_data;
         pd_s2_q   <= pd_s1_q;
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         wd_q      <= wd_d;
         brk_f_q   <= brk_f_d;
         ext_f_q   <= ext_f_d;
         code_q    <= code_d;
         ext_q     <= ext_d;
         recv_q    <= recv_d;
         rel_q     <= rel_d;
         err_q     <= err_d;
      end
   end

   assign code = code_q;
   assign ext  = ext_q;
   assign recv = recv_q;
   assign rel  = rel_q;
   assign err  = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Randomized bench for ps2_scancode_rx against a byte-level event model.
module tb_ps2_scancode_rx;

   localparam int unsigned TO = 100;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] code;
   logic       ext, recv, rel, err;

   ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .code(code), .ext(ext), .recv(recv), .rel(rel), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Event kinds: 0 none, 1 make, 2 break, 3 error
   typedef struct {
      int         kind;
      logic [7:0] code;
      logic       ext;
      int         cyc;
   } ev_t;

   ev_t obs_q[$];

   always @(negedge clk) begin
      if (rstn && (recv || rel || err)) begin
         ev_t e;
         chk("pulse_excl", 32'($countones({recv, rel, err})), 32'd1);
         e.kind = recv ? 1 : (rel ? 2 : 3);
         e.code = code;
         e.ext  = ext;
         e.cyc  = cyc;
         obs_q.push_back(e);
      end
   end

   // Reference model state
   bit         m_brk = 0, m_extf = 0;
   logic [7:0] m_code = 8'h00;
   logic       m_ext = 1'b0;

   function automatic ev_t model_frame(input logic [7:0] b, input bit good);
      ev_t e;
      e.kind = 0; e.code = m_code; e.ext = m_ext; e.cyc = 0;
      if (!good) begin
         m_brk = 0; m_extf = 0; e.kind = 3;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b == 8'hE0) begin
         m_extf = 1;
      end else begin
         e.kind = m_brk ? 2 : 1;
         m_code = b; m_ext = m_extf;
         e.code = b; e.ext = m_extf;
         m_brk = 0; m_extf = 0;
      end
      return e;
   endfunction

   task automatic ps2_bit(input logic b, output int fall_cyc);
      ps2_data = b;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      repeat (20) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      ev_t e;
      logic [10:0] bits;
      int f;
      e = model_frame(b, !(bad_par || bad_stop));
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      obs_q.delete();
      for (int i = 0; i < 11; i++) ps2_bit(bits[i], f);
      chk("n_events", 32'(obs_q.size()), (e.kind != 0) ? 32'd1 : 32'd0);
      if (obs_q.size() > 0 && e.kind != 0) begin
         chk("ev_kind", 32'(obs_q[0].kind), 32'(e.kind));
         chk("ev_code", 32'(obs_q[0].code), 32'(e.code));
         chk("ev_ext", 32'(obs_q[0].ext), 32'(e.ext));
         // two synchronizer stages plus the edge detector before the output flop
         chk("ev_latency", 32'(obs_q[0].cyc - f), 32'd3);
      end
      chk("code_hold", 32'(code), 32'(m_code));
      chk("ext_hold", 32'(ext), 32'(m_ext));
   endtask

   task automatic check_idle_outputs(input string tag);
      chk(tag, 32'({code, ext, recv, rel, err}), 32'd0);
   endtask

   initial begin
      int f;
      logic [7:0] b;
      int r;

      repeat (3) @(negedge clk);
      check_idle_outputs("reset_outputs");
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      check_idle_outputs("post_reset_outputs");

      // Directed plan
      do_frame(8'h1C, 0, 0);
      do_frame(8'hF0, 0, 0);
      do_frame(8'h1C, 0, 0);
      do_frame(8'hE0, 0, 0); do_frame(8'hF0, 0, 0); do_frame(8'h75, 0, 0);
      do_frame(8'hF0, 0, 0); do_frame(8'hE0, 0, 0); do_frame(8'h75, 0, 0);
      do_frame(8'hE0, 0, 0); do_frame(8'hE0, 0, 0); do_frame(8'h75, 0, 0);
      do_frame(8'h1C, 1, 0);
      do_frame(8'hF0, 0, 0); do_frame(8'h1C, 0, 1); do_frame(8'h1C, 0, 0);

      // Truncated frame after a break prefix: watchdog must drop it and clear flags
      do_frame(8'hF0, 0, 0);
      obs_q.delete();
      ps2_bit(1'b0, f);
      b = 8'h29;
      for (int i = 0; i < 5; i++) ps2_bit(b[i], f);
      void'(model_frame(8'h00, 0));
      for (int i = 0; i < 300 && obs_q.size() == 0; i++) @(negedge clk);
      chk("to_events", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) begin
         chk("to_kind", 32'(obs_q[0].kind), 32'd3);
         chk("to_latency", 32'(obs_q[0].cyc - f), 32'(TO + 3));
      end
      repeat (20) @(negedge clk);
      do_frame(8'h29, 0, 0);

      // Reset in the middle of a frame
      ps2_bit(1'b0, f);
      ps2_bit(1'b1, f);
      ps2_bit(1'b0, f);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      m_code = 8'h00; m_ext = 1'b0; m_brk = 0; m_extf = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_idle_outputs("in_reset_outputs");
      end
      rstn = 1'b1;
      repeat (10) @(negedge clk);
      do_frame(8'h1C, 0, 0);

      // Randomized traffic with prefixes and corrupted frames
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         if (r < 2) b = 8'hF0;
         else if (r < 4) b = 8'hE0;
         else b = 8'($urandom);
         r = $urandom_range(0, 7);
         do_frame(b, r == 0, r == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and assembles each 11-bit frame into a byte. It resolves the `0xE0` (extended) and `0xF0` (break) prefixes into make/break events and emits them as single-cycle pulses. It sits directly upstream of the key-pressed controller. `recv` drives that controller's press input and `rel` drives its release input.

## Interface
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a `ps2_clk` falling edge, while a frame is in progress, after which the frame is aborted (500 µs at 100 MHz).
- `clk`  in  1  system clock. All logic uses the rising edge.
- `rstn`  in  1  reset. Asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `code`  out  8  last delivered scancode. Holds its value until the next delivery.
- `ext`  out  1  the last delivered code was `0xE0`-prefixed. Updated together with `code`.
- `recv`  out  1  one-cycle pulse: a make code was delivered.
- `rel`  out  1  one-cycle pulse: a break code was delivered (the code followed `0xF0`).
- `err`  out  1  one-cycle pulse: the frame was dropped because of bad parity, a bad stop bit, or a timeout.

## Operation
- **Synchronizer.** Two flops on each pin, plus a third flop on the synchronized clock for edge detection.
  - All of these flops reset to 1 (idle bus), so reset release cannot produce a spurious edge.
  - Sample event = synchronized `ps2_clk` falling (previous value 1, current value 0). Rising edges are ignored.
  - The data bit is taken from the synchronized `ps2_data` in the same cycle as the sample event.
- **Frame FSM.** States IDLE, DATA, PARITY, STOP. Transitions happen only on sample events, except for the timeout.
  - IDLE: data = 0 → DATA, with the bit counter cleared. Data = 1 → stay in IDLE; this is not an error.
  - DATA: shift in 8 bits, LSB first. After the 8th bit → PARITY.
  - PARITY: capture the parity bit → STOP.
  - STOP: the frame is good iff the XOR of the 8 data bits and the parity bit is 1 (odd parity) AND the stop bit is 1. Always → IDLE.
- **Watchdog.** The counter clears on every sample event and also while in IDLE.
  - When the counter reaches `TIMEOUT_CYCLES-1` outside IDLE: go to IDLE, pulse `err`, clear both prefix flags.
  - The counter saturates; it never wraps.
- **Byte layer** (acts on good frames only):
  - `0xF0` → set `brk_f`. No output.
  - `0xE0` → set `ext_f`. No output.
  - Any other byte:
    - `code` ← byte and `ext` ← `ext_f`.
    - Pulse `rel` if `brk_f` is set, otherwise pulse `recv`.
    - Clear both flags.
  - Prefix order does not matter: `E0 F0 xx` and `F0 E0 xx` both give `rel` with `ext`=1.
  - A repeated prefix is idempotent.
- **Bad frame** (parity or stop failure): pulse `err`, discard the byte, clear both flags, leave `code`/`ext` unchanged.
- `recv`, `rel` and `err` are mutually exclusive; at most one is high in any cycle.

## Timing
- **Reset values:** `code`=0x00, `ext`=0, `recv`=0, `rel`=0, `err`=0, FSM in IDLE, flags clear, watchdog at 0.
- **Reset mid-frame:** the frame is abandoned with no pulse. After release, the first falling edge with data=0 starts a new frame.
- **Latency:** when the stop-bit falling edge arrives at the `ps2_clk` pin, the output pulse (`recv`/`rel`/`err`) is registered on the 3rd rising `clk` edge after it.
  - `code`/`ext` update on that same edge.
- **Pulse width:** exactly one `clk` cycle, and fully registered (no combinational output path). Consumers sampling on either clock edge will capture it.
- **Timeout:** `err` is registered `TIMEOUT_CYCLES` cycles after the last sample event.
- **Throughput:** a new start bit is accepted on the first sample event after STOP; there is no dead time.
- **Clock ratio:** requires ≥ 4 `clk` cycles per `ps2_clk` half-period.

## Test plan
Bench settings: `ps2_clk` half-period = 20 `clk` cycles, `TIMEOUT_CYCLES`=100.

1. Frame `0x1C` with parity 0 and stop 1 → a single `recv` pulse, `code`=0x1C, `ext`=0, no `rel`/`err`.
2. `F0` then `1C` → no pulse after the `F0`; after the `1C`, a single `rel` pulse with `code`=0x1C and `ext`=0.
3. `E0 F0 75` and `F0 E0 75` → each gives a single `rel` with `code`=0x75, `ext`=1. `E0 75` → `recv` with `ext`=1.
4. `0x1C` with parity flipped → `err` pulse, `code` keeps its prior value. Then `F0`, followed by a bad-stop frame, followed by `1C` → `err`, then `recv` (not `rel`).
5. Stop after 5 data bits → `err` 100 cycles after the last falling edge, FSM in IDLE. The next full `0x29` frame → `recv` with `code`=0x29.
6. Assert `rstn` mid-frame, release it, send `0x1C` → no pulse during reset, all outputs 0 during reset, then a clean `recv` with `code`=0x1C.
